// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // A src_id field is never narrower than one bit, even for two requesters.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority search: returns the first set request at or after ptr, wrapping modulo NUM.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM = 4,
    localparam int IDW = clog2_min1(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    function automatic int rot(input logic [IDW-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        return (j >= NUM) ? j - NUM : j;
    endfunction

    // Scan from the farthest offset back to ptr so the nearest requester is the last assignment and wins.
    always_comb begin
        // NOTE: outputs get defaults before the loop so every path assigns them; otherwise a latch is inferred.
        any = 1'b0;
        idx = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (req[rot(ptr, k)]) begin
                any = 1'b1;
                idx = IDW'(rot(ptr, k));
            end
        end
    end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Packet-granular round-robin sharing of one FIFO write port; each word is tagged {last, src_id, payload}.
module fifo_wr_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM   = 4,
    parameter  int DSIZE = 144,
    localparam int IDW   = clog2_min1(NUM),
    localparam int PW    = DSIZE - 1 - IDW
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [NUM*PW-1:0] s_data,
    input  logic [NUM-1:0]    s_valid,
    input  logic [NUM-1:0]    s_last,
    output logic [NUM-1:0]    s_ready,
    output logic [DSIZE-1:0]  fifo_din,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    output logic [31:0]       pkt_cnt
);

    arb_state_e     state;
    logic [IDW-1:0] rr_ptr;
    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic           own_valid;
    logic           own_last;
    logic           accept;

    rr_priority_pick #(.NUM(NUM)) u_pick (
        .req (s_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign own_valid  = s_valid[grant_id];
    assign own_last   = s_last[grant_id];
    assign accept     = (state == LOCK) && !fifo_full && own_valid;
    assign fifo_wr_en = accept;
    // The data path is a pure mux on the owner; non-owner data never reaches the FIFO.
    assign fifo_din   = {own_last, grant_id, s_data[int'(grant_id) * PW +: PW]};

    always_comb begin
        s_ready = '0;
        if (state == LOCK && !fifo_full) begin
            s_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        state    <= LOCK;
                        busy     <= 1'b1;
                    end
                end
                LOCK: begin
                    // The grant is held through stalls and valid gaps; only the last beat releases it.
                    if (accept && own_last) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        rr_ptr  <= (grant_id == IDW'(NUM - 1)) ? '0 : grant_id + 1'b1;
                        pkt_cnt <= pkt_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
